// File: rtl/tmr_fault_monitor_if.sv
// Pin bundle for tmr_fault_monitor: io_in carries clock, reset, lanes and control;
// io_out carries voted/mis/alarm and the selectable count/status field.
interface tmr_fault_monitor_if;
    logic [7:0] io_in;
    logic [7:0] io_out;

    modport master (output io_in, input io_out);
    modport slave (input io_in, output io_out);
endinterface

// File: rtl/tmr_fault_monitor.sv
// Majority voter and fault monitor for a triplicated register stage.
// Define TMR_MON_SYNC_EN to put a 2-flop synchronizer on the lanes before voting.
module tmr_fault_monitor (
    tmr_fault_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StMonitor  = 2'b01,
        StDegraded = 2'b10,
        StAlarm    = 2'b11
    } state_e;

    logic       clk;
    logic       rst_n;
    logic [2:0] lanes_raw;
    logic       en;
    logic       clr;
    logic       view;

    assign clk       = bus.io_in[0];
    assign rst_n     = bus.io_in[1];
    assign lanes_raw = bus.io_in[4:2];
    assign en        = bus.io_in[5];
    assign clr       = bus.io_in[6];
    assign view      = bus.io_in[7];

    // lanes[0] = A, lanes[1] = B, lanes[2] = C
    logic [2:0] lanes;

`ifdef TMR_MON_SYNC_EN
    logic [2:0] sync_meta_q;
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_q <= 3'b000;
            sync_q      <= 3'b000;
        end else begin
            sync_meta_q <= lanes_raw;
            sync_q      <= sync_meta_q;
        end
    end

    assign lanes = sync_q;
`else
    assign lanes = lanes_raw;
`endif

    logic       maj;
    logic       mismatch;
    logic [2:0] fault;

    assign maj      = (lanes[0] & lanes[1]) | (lanes[0] & lanes[2]) | (lanes[1] & lanes[2]);
    assign mismatch = (|lanes) & ~(&lanes);
    // With three binary lanes exactly one lane disagrees with the majority on a mismatch.
    assign fault    = lanes ^ {3{maj}};

    state_e     state_q, state_d;
    logic [2:0] flags_q, flags_d;
    logic [4:0] cnt_q, cnt_d;
    logic       mis_q, mis_d;
    logic       voted_q;
    logic       multi_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            flags_q <= 3'b000;
            cnt_q   <= 5'd0;
            mis_q   <= 1'b0;
            voted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            voted_q <= maj;
        end
    end

    // Transitions look at the post-update flags and counter.
    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        cnt_d      = cnt_q;
        mis_d      = 1'b0;
        multi_flag = 1'b0;
        if (clr) begin
            flags_d = 3'b000;
            cnt_d   = 5'd0;
            state_d = en ? StMonitor : StIdle;
        end else begin
            if (state_q != StIdle && mismatch) begin
                mis_d   = 1'b1;
                flags_d = flags_q | fault;
                if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
            end
            multi_flag = (flags_d[0] & flags_d[1]) | (flags_d[0] & flags_d[2]) |
                         (flags_d[1] & flags_d[2]);
            unique case (state_q)
                StIdle: begin
                    if (en) state_d = StMonitor;
                end
                StMonitor: begin
                    if (|flags_d) state_d = StDegraded;
                    else if (!en) state_d = StIdle;
                end
                StDegraded: begin
                    if (multi_flag || cnt_d == 5'd31) state_d = StAlarm;
                    else if (!en) state_d = StIdle;
                end
                StAlarm: begin
                    state_d = StAlarm;
                end
            endcase
        end
    end

    logic [4:0] field;

    assign field      = view ? {flags_q[0], flags_q[1], flags_q[2], state_q} : cnt_q;
    assign bus.io_out = {field, state_q == StAlarm, mis_q, voted_q};

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Scoreboard bench for tmr_fault_monitor: a reference model predicts io_out each cycle,
// plus fixed-value checks on the key scenarios.
module tb_tmr_fault_monitor;
    tmr_fault_monitor_if bus ();

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] lanes;
    logic       en;
    logic       clr;
    logic       view;

    assign bus.io_in = {view, clr, en, lanes, rst_n, clk};

    tmr_fault_monitor dut (.bus(bus));

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];

    int         m_state;
    logic [2:0] m_flags;
    int         m_cnt;
    logic       m_voted;
    logic       m_mis;
    logic [2:0] m_s1;
    logic [2:0] m_s2;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_flags = 3'b000;
        m_cnt   = 0;
        m_voted = 1'b0;
        m_mis   = 1'b0;
        m_s1    = 3'b000;
        m_s2    = 3'b000;
    endtask

    task automatic model_step(input logic [2:0] l, input logic e, input logic c);
        logic [2:0] s;
        int         ones;
        int         nflags;
        logic       mj;
`ifdef TMR_MON_SYNC_EN
        s    = m_s2;
        m_s2 = m_s1;
        m_s1 = l;
`else
        s = l;
`endif
        ones    = int'(s[0]) + int'(s[1]) + int'(s[2]);
        mj      = (ones >= 2);
        m_voted = mj;
        m_mis   = 1'b0;
        if (c) begin
            m_flags = 3'b000;
            m_cnt   = 0;
            m_state = e ? 1 : 0;
        end else begin
            if (m_state != 0 && ones != 0 && ones != 3) begin
                m_mis = 1'b1;
                for (int i = 0; i < 3; i++) if (s[i] != mj) m_flags[i] = 1'b1;
                if (m_cnt < 31) m_cnt++;
            end
            nflags = int'(m_flags[0]) + int'(m_flags[1]) + int'(m_flags[2]);
            case (m_state)
                0: if (e) m_state = 1;
                1: if (nflags > 0) m_state = 2; else if (!e) m_state = 0;
                2: if (nflags >= 2 || m_cnt == 31) m_state = 3; else if (!e) m_state = 0;
                default: ;
            endcase
        end
    endtask

    function automatic logic [7:0] model_out(input logic v);
        logic [4:0] f;
        f = v ? {m_flags[0], m_flags[1], m_flags[2], 2'(m_state)} : 5'(m_cnt);
        return {f, m_state == 3, m_mis, m_voted};
    endfunction

    // One clock: drive at negedge, predict, sample 1 ns after the rising edge.
    task automatic cycle(input logic [2:0] l, input logic e, input logic c, input logic v);
        logic [7:0] exp;
        lanes = l;
        en    = e;
        clr   = c;
        view  = v;
        model_step(l, e, c);
        exp_q.push_back(model_out(v));
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check("scoreboard", bus.io_out, exp);
        @(negedge clk);
    endtask

    int mis_at;

    initial begin
        rst_n = 1'b0;
        lanes = 3'b000;
        en    = 1'b0;
        clr   = 1'b0;
        view  = 1'b0;
        model_reset();
        #1;
        check("reset_out", bus.io_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (4) cycle(3'b111, 1'b1, 1'b0, 1'b0);
        cycle(3'b111, 1'b1, 1'b0, 1'b1);
`ifndef TMR_MON_SYNC_EN
        check("monitor_status", bus.io_out, 8'h09);

        // A wrong
        cycle(3'b110, 1'b1, 1'b0, 1'b0);
        check("single_fault", bus.io_out, 8'h0B);
        cycle(3'b111, 1'b1, 1'b0, 1'b1);
        check("degraded_status", bus.io_out, 8'h91);

        // B wrong against a 0 majority -> second flag -> alarm
        cycle(3'b010, 1'b1, 1'b0, 1'b0);
        check("alarm_entry", bus.io_out, 8'h16);
        cycle(3'b000, 1'b0, 1'b0, 1'b1);
        check("alarm_sticky", bus.io_out, 8'hDC);
        cycle(3'b000, 1'b0, 1'b1, 1'b0);
        check("clr_to_idle", bus.io_out, 8'h00);

        // Disable from DEGRADED holds flags and count; IDLE ignores mismatches
        cycle(3'b111, 1'b1, 1'b0, 1'b0);
        cycle(3'b011, 1'b1, 1'b0, 1'b0);
        cycle(3'b111, 1'b0, 1'b0, 1'b1);
        check("idle_hold_status", bus.io_out, 8'h21);
        repeat (3) cycle(3'b011, 1'b0, 1'b0, 1'b0);
        check("idle_ignores", bus.io_out, 8'h09);

        // C wrong for 40 cycles: saturate, then alarm
        cycle(3'b111, 1'b1, 1'b1, 1'b0);
        repeat (40) cycle(3'b011, 1'b1, 1'b0, 1'b0);
        check("saturate", bus.io_out, 8'hFF);
        cycle(3'b111, 1'b1, 1'b0, 1'b1);
        check("saturate_status", bus.io_out, 8'h3D);

        // clr beats a simultaneous mismatch
        cycle(3'b011, 1'b1, 1'b1, 1'b0);
        check("clr_priority", bus.io_out, 8'h01);
        cycle(3'b111, 1'b1, 1'b0, 1'b1);
        check("clr_flags", bus.io_out, 8'h09);
        cycle(3'b111, 1'b0, 1'b1, 1'b0);
        repeat (3) cycle(3'b101, 1'b0, 1'b0, 1'b0);
        check("disabled_count", bus.io_out, 8'h01);
`endif

        // Reach ALARM, then pulse reset between edges
        repeat (3) cycle(3'b111, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle(3'b110, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle(3'b101, 1'b1, 1'b0, 1'b0);
        repeat (2) cycle(3'b111, 1'b1, 1'b0, 1'b0);
        check("pre_reset_alarm", {7'd0, bus.io_out[2]}, 8'h01);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset", bus.io_out, 8'h00);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        cycle(3'b111, 1'b0, 1'b0, 1'b1);
        check("post_reset_idle", {6'd0, bus.io_out[7:6]}, 8'h00);

        // mis latency: 0 extra cycles direct, 2 extra with the synchronizer
        repeat (3) cycle(3'b111, 1'b1, 1'b0, 1'b0);
        mis_at = -1;
        for (int i = 0; i < 4; i++) begin
            cycle((i == 0) ? 3'b110 : 3'b111, 1'b1, 1'b0, 1'b0);
            if (bus.io_out[1] && mis_at < 0) mis_at = i;
        end
`ifdef TMR_MON_SYNC_EN
        check("mis_latency", 8'(mis_at), 8'd2);
`else
        check("mis_latency", 8'(mis_at), 8'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
